// File: rtl/cnn_pkg.sv
// cnn_pkg: widths and FSM states shared by the CNN window datapath.
package cnn_pkg;
    localparam int PIX_W  = 8;
    localparam int WGT_W  = 8;
    localparam int ACC_W  = 20;
    localparam int WIN_N  = 16;
    localparam int PROD_W = 16;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/window_mac_if.sv
// window_mac_if: control, shift-buffer, weight-load and result signals of window_mac.
interface window_mac_if;
    import cnn_pkg::*;
    logic             start;
    logic [PIX_W-1:0] sb_out;
    logic             sb_readEn;
    logic             w_we;
    logic [3:0]       w_addr;
    logic [WGT_W-1:0] w_data;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             busy;
    modport master (output start, sb_out, w_we, w_addr, w_data,
                    input  sb_readEn, result, result_valid, busy);
    modport slave  (input  start, sb_out, w_we, w_addr, w_data,
                    output sb_readEn, result, result_valid, busy);
endinterface

// File: rtl/window_weight_rf.sv
// window_weight_rf: 16x8 weight store, sync write, comb read, sync clear.
module window_weight_rf
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [WGT_W-1:0] wdata,
    input  logic [3:0]       raddr,
    output logic [WGT_W-1:0] rdata
);
    logic [WGT_W-1:0] mem_q [WIN_N];
    logic [WGT_W-1:0] mem_d [WIN_N];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/window_mac.sv
// window_mac: reads a 16-pixel window from the shift buffer and emits the weighted sum.
module window_mac
    import cnn_pkg::*;
#(
    parameter bit RELU = 1'b0
) (
    input logic        clk,
    input logic        rst,
    window_mac_if.slave bus
);
    state_e                  state_q, state_d;
    logic [3:0]              rd_cnt_q, rd_cnt_d, k_q, k_d;
    logic                    vld_q, vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, result_q, result_d;
    logic [WGT_W-1:0]        wgt;
    logic signed [PROD_W-1:0] prod;

    window_weight_rf u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.w_we && state_q == IDLE),
        .waddr (bus.w_addr),
        .wdata (bus.w_data),
        .raddr (k_q),
        .rdata (wgt)
    );

    // Pixel is unsigned, so it is zero-extended before the signed multiply
    always_comb begin
        prod     = $signed({8'b0, bus.sb_out}) * $signed({{8{wgt[WGT_W-1]}}, wgt});
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        acc_d    = vld_q ? acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : acc_q;
        result_d = result_q;
        vld_d    = state_q == READ;
        k_d      = rd_cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = READ;
                rd_cnt_d = '0;
                acc_d    = '0;
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + 4'd1;
                state_d  = rd_cnt_q == 4'(WIN_N-1) ? DRAIN : READ;
            end
            DRAIN: begin
                state_d  = DONE;
                result_d = (RELU && acc_d[ACC_W-1]) ? '0 : acc_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            k_q      <= '0;
            vld_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            k_q      <= k_d;
            vld_q    <= vld_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.sb_readEn    = state_q == READ;
    assign bus.result_valid = state_q == DONE;
    assign bus.busy         = state_q != IDLE;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_window_mac.sv
// tb_window_mac: scoreboard bench for window_mac (RELU off and on) with a shift-buffer model.
module tb_window_mac;
    import cnn_pkg::*;

    typedef struct {
        logic [19:0] val;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_mac_if b0 ();
    window_mac_if b1 ();

    assign b1.start  = b0.start;
    assign b1.sb_out = b0.sb_out;
    assign b1.w_we   = b0.w_we;
    assign b1.w_addr = b0.w_addr;
    assign b1.w_data = b0.w_data;

    window_mac #(.RELU(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    window_mac #(.RELU(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ren_cnt = 0;
    int          idx = 0;
    bit          pend = 0;
    logic [7:0]  pix [16];
    int          wm [16];
    exp_t        q0[$];
    exp_t        q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Shift buffer: a pixel appears the cycle after each read enable
    initial forever begin
        @(negedge clk);
        if (rst) pend = 0;
        else begin
            if (pend) begin
                b0.sb_out = pix[idx];
                idx = (idx + 1) % 16;
            end
            pend = b0.sb_readEn;
            if (b0.sb_readEn) ren_cnt++;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && b0.result_valid) begin
            if (q0.size() == 0) check("unexpected_valid0", 1, 0);
            else begin
                e = q0.pop_front();
                check("result_relu0", {12'b0, b0.result}, {12'b0, e.val});
                check("latency0", cyc, e.at);
                check("readEn_cycles", ren_cnt, 16);
            end
        end
        if (!rst && b1.result_valid) begin
            if (q1.size() == 0) check("unexpected_valid1", 1, 0);
            else begin
                e = q1.pop_front();
                check("result_relu1", {12'b0, b1.result}, {12'b0, e.val});
                check("latency1", cyc, e.at);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        b0.start = 1'b0;
        b0.w_we  = 1'b0;
    endtask

    task automatic step(input bit st, input bit we, input int k, input logic [7:0] v);
        int   s;
        exp_t e;
        tick();
        b0.start  = st;
        b0.w_we   = we;
        b0.w_addr = k[3:0];
        b0.w_data = v;
        if (!b0.busy) begin
            if (we) wm[k] = int'($signed(v));
            if (st) begin
                s = 0;
                for (int i = 0; i < 16; i++) s += int'(pix[i]) * wm[i];
                idx     = 0;
                ren_cnt = 0;
                e.at    = cyc + 18;
                e.val   = s[19:0];
                q0.push_back(e);
                e.val   = (s < 0) ? 20'd0 : s[19:0];
                q1.push_back(e);
            end
        end
    endtask

    task automatic load_all(input logic [7:0] v);
        for (int k = 0; k < 16; k++) step(0, 1, k, v);
    endtask

    task automatic load_rand();
        for (int k = 0; k < 16; k++) step(0, 1, k, 8'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!b0.busy && q0.size() == 0 && q1.size() == 0) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    initial begin
        b0.start  = 1'b0;
        b0.sb_out = '0;
        b0.w_we   = 1'b0;
        b0.w_addr = '0;
        b0.w_data = '0;
        for (int i = 0; i < 16; i++) begin
            wm[i]  = 0;
            pix[i] = 8'($urandom);
        end
        repeat (2) @(negedge clk);
        check("rst_result", {12'b0, b0.result}, 0);
        check("rst_valid", {31'b0, b0.result_valid}, 0);
        check("rst_busy", {31'b0, b0.busy}, 0);
        check("rst_readEn", {31'b0, b0.sb_readEn}, 0);
        rst = 1'b0;

        step(1, 0, 0, 0);
        drain();

        load_all(8'd1);
        for (int i = 0; i < 16; i++) pix[i] = 8'(i + 1);
        step(1, 0, 0, 0);
        drain();

        load_all(8'hFF);
        for (int i = 0; i < 16; i++) pix[i] = 8'd255;
        step(1, 0, 0, 0);
        drain();

        load_all(8'd127);
        step(1, 0, 0, 0);
        drain();

        for (int n = 0; n < 6; n++) begin
            load_rand();
            for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
            step(1, 1, 5, 8'($urandom));
            drain();
        end

        // Ignored start/write mid-window, then back-to-back start in c19
        load_rand();
        for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
        step(1, 0, 0, 0);
        for (int c = 1; c <= 19; c++) begin
            if (c == 19) for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
            step(c == 5 || c == 19, c == 7, 3, 8'($urandom));
        end
        drain();

        // Reset in c8 of a window
        load_all(8'd1);
        for (int i = 0; i < 16; i++) pix[i] = 8'(i + 1);
        step(1, 0, 0, 0);
        repeat (7) tick();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 16; i++) wm[i] = 0;
        tick();
        rst = 1'b0;
        check("readEn_after_rst", {31'b0, b0.sb_readEn}, 0);
        check("busy_after_rst", {31'b0, b0.busy}, 0);
        repeat (20) tick();
        load_all(8'd1);
        step(1, 0, 0, 0);
        drain();

        check("queue0_empty", q0.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
